// File: rtl/alu_display_pkg.sv
// alu_display_pkg
// Shared definitions for the ALU result display block:
//   - state_e      : conversion FSM states (IDLE, CONVERT, DONE)
//   - SEG_*        : active-low 7-segment patterns {g,f,e,d,c,b,a}
//   - NUM_DIGITS   : number of multiplexed display digits
//   - seg_decode() : BCD nibble to segment pattern, blank for 10..15
package alu_display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/alu_bin2bcd.sv
// alu_bin2bcd
// Sequential double-dabble (shift-add-3) converter, one bit per cycle.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load bin and begin a conversion (ignored state is overwritten)
//   bin        : unsigned binary input, WIDTH bits (1..13)
//   done       : high during the cycle whose edge performs the last shift
//   bcd        : 4-digit BCD result, valid from the edge after done
module alu_bin2bcd #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             done,
  output logic [15:0]      bcd
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] bin_q;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [11:0]      adj;

  // Only the lower three digits ever need the +3 correction: with results
  // capped at 8191 the thousands digit is at most 4 before the final shift.
  always_comb begin
    adj = '0;
    for (int i = 0; i < 3; i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? (bcd[4*i +: 4] + 4'd3)
                                               : bcd[4*i +: 4];
    end
  end

  assign done = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      bin_q <= bin;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      bcd   <= {bcd[14:12], adj, bin_q[WIDTH-1]};
      bin_q <= bin_q << 1;
      cnt   <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_result_display.sv
// alu_result_display
// Captures an ALU result and its Z/Cout flags, converts the result to BCD
// and shows it on a 4-digit multiplexed active-low 7-segment display.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   in_valid, in_ready : capture handshake
//   alu_result         : unsigned result, WIDTH bits (1..13)
//   alu_z, alu_cout    : ALU flags
//   seg                : segments {g,f,e,d,c,b,a}, active-low
//   an                 : digit anodes, active-low one-hot, an[0] = units
//   led_z, led_cout    : flags of the result currently displayed
// Parameters: WIDTH (1..13), REFRESH_DIV (>=2 cycles per digit).
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module alu_result_display
  import alu_display_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_cout,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             led_z,
  output logic             led_cout
);

  localparam int SCAN_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  state_e            state;
  logic              capture;
  logic              z_q;
  logic              cout_q;
  logic [15:0]       disp;
  logic              eng_done;
  logic [15:0]       eng_bcd;
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  idx;
  logic              active;
  logic [3:0]        nib;
  logic              blank;

  // Handshake: a capture happens on any edge where in_valid && in_ready.
  // in_ready is high only in IDLE; in_valid while busy is simply ignored,
  // and the source is expected to hold in_valid until it sees in_ready.
  assign in_ready = (state == ST_IDLE);
  assign capture  = in_valid && in_ready;

  alu_bin2bcd #(.WIDTH(WIDTH)) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (capture),
    .bin   (alu_result),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  // Flags are held aside during conversion so digits and LEDs change together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      z_q      <= 1'b0;
      cout_q   <= 1'b0;
      disp     <= '0;
      led_z    <= 1'b0;
      led_cout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (capture) begin
            state  <= ST_CONVERT;
            z_q    <= alu_z;
            cout_q <= alu_cout;
          end
        end
        ST_CONVERT: begin
          if (eng_done) state <= ST_DONE;
        end
        ST_DONE: begin
          disp     <= eng_bcd;
          led_z    <= z_q;
          led_cout <= cout_q;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Free-running digit scan. 'active' keeps the display dark while in reset
  // and lights digit 0 from the first edge after release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      active   <= 1'b0;
    end else begin
      active <= 1'b1;
      if (scan_cnt == SCAN_W'(REFRESH_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    nib   = disp[{idx, 2'b00} +: 4];
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every higher digit is zero.
    case (idx)
      2'd3:    blank = (disp[15:12] == 4'd0);
      2'd2:    blank = (disp[15:8]  == 8'd0);
      2'd1:    blank = (disp[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    if (!active) begin
      seg = SEG_BLANK;
      an  = 4'hF;
    end else begin
      seg = blank ? SEG_BLANK : seg_decode(nib);
      an  = ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
// tb_alu_result_display
// Three instances (WIDTH 4, 13, 1) share clock, reset and the result bus;
// each has its own in_valid. REFRESH_DIV=4 so all digits scan in 16 cycles.
module tb_alu_result_display;

  localparam int RD = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit         LZ  = 1'b1;
  localparam logic [6:0] LZB = 7'h7F;
`else
  localparam bit         LZ  = 1'b0;
  localparam logic [6:0] LZB = 7'h40;
`endif

  typedef struct {
    int          sel;
    int          val;
    bit          z;
    bit          cout;
    bit          poke;
    logic [27:0] exp;   // {d3,d2,d1,d0}
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  valid;
  logic [12:0] res;
  logic        z, cout;
  logic [2:0]  rdy, lz, lc;
  logic [6:0]  seg_a [3];
  logic [3:0]  an_a  [3];

  int vectors = 0;
  int miscompares = 0;
  logic [6:0] exp_q[$];
  logic [6:0] pat_tab [10];
  vec_t tab [8];

  always #5 clk = ~clk;

  alu_result_display #(.WIDTH(4), .REFRESH_DIV(RD)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid[0]), .in_ready(rdy[0]),
    .alu_result(res[3:0]), .alu_z(z), .alu_cout(cout),
    .seg(seg_a[0]), .an(an_a[0]), .led_z(lz[0]), .led_cout(lc[0]));

  alu_result_display #(.WIDTH(13), .REFRESH_DIV(RD)) u_w13 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid[1]), .in_ready(rdy[1]),
    .alu_result(res[12:0]), .alu_z(z), .alu_cout(cout),
    .seg(seg_a[1]), .an(an_a[1]), .led_z(lz[1]), .led_cout(lc[1]));

  alu_result_display #(.WIDTH(1), .REFRESH_DIV(RD)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid[2]), .in_ready(rdy[2]),
    .alu_result(res[0:0]), .alu_z(z), .alu_cout(cout),
    .seg(seg_a[2]), .an(an_a[2]), .led_z(lz[2]), .led_cout(lc[2]));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int wid(input int s);
    case (s)
      0:       return 4;
      1:       return 13;
      default: return 1;
    endcase
  endfunction

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  // Reference: decimal digit k of v, blanked when it is a leading zero.
  function automatic logic [6:0] model_seg(input int v, input int k);
    if (LZ && k > 0 && v < pow10(k)) return 7'h7F;
    return pat_tab[(v / pow10(k)) % 10];
  endfunction

  function automatic logic [27:0] model_digits(input int v);
    return {model_seg(v, 3), model_seg(v, 2), model_seg(v, 1), model_seg(v, 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input int s, input string tag);
    int n = 0;
    while (!rdy[s] && n < 60) begin
      tick();
      n++;
    end
    chk({tag, " ready_wait"}, 32'(rdy[s]), 32'd1);
  endtask

  // Scan through all digits once and compare against the scoreboard queue.
  task automatic read_digits(input int s, input string tag);
    logic [6:0] seen [4];
    int bad = 0;
    logic [6:0] e;
    for (int k = 0; k < 4; k++) seen[k] = 'x;
    for (int c = 0; c < 4 * RD + 4; c++) begin
      case (an_a[s])
        4'hE:    seen[0] = seg_a[s];
        4'hD:    seen[1] = seg_a[s];
        4'hB:    seen[2] = seg_a[s];
        4'h7:    seen[3] = seg_a[s];
        default: bad++;
      endcase
      tick();
    end
    chk({tag, " an_onehot"}, 32'(bad), 32'd0);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s digit%0d", tag, k), {25'd0, seen[k]}, {25'd0, e});
    end
  endtask

  task automatic push_exp(input logic [27:0] ed);
    for (int k = 0; k < 4; k++) exp_q.push_back(ed[7*k +: 7]);
  endtask

  task automatic send(input int s, input int v, input bit zz, input bit cc,
                      input bit poke, input logic [27:0] ed, input string tag);
    int w = wid(s);
    int cycles = 0;
    wait_ready(s, tag);
    res = 13'(v);
    z = zz;
    cout = cc;
    valid[s] = 1'b1;
    tick();
    valid[s] = 1'b0;
    // Scramble inputs: the conversion must use the captured values.
    res = 13'($urandom);
    z = ~zz;
    cout = ~cc;
    chk({tag, " busy_after_capture"}, 32'(rdy[s]), 32'd0);
    while (!rdy[s] && cycles < 60) begin
      if (poke && cycles == 0) begin
        valid[s] = 1'b1;
        res = 13'd2;
      end else begin
        valid[s] = 1'b0;
      end
      tick();
      cycles++;
    end
    valid[s] = 1'b0;
    chk({tag, " ready_low_cycles"}, 32'(cycles), 32'(w + 1));
    chk({tag, " led_z"}, 32'(lz[s]), 32'(zz));
    chk({tag, " led_cout"}, 32'(lc[s]), 32'(cc));
    if (poke) begin
      tick();
      chk({tag, " no_capture_of_poke"}, 32'(rdy[s]), 32'd1);
    end
    push_exp(ed);
    read_digits(s, tag);
  endtask

  initial begin
    int v, run;
    bit rz, rc;
    logic [3:0] scan_seq [4];

    pat_tab[0] = 7'h40; pat_tab[1] = 7'h79; pat_tab[2] = 7'h24; pat_tab[3] = 7'h30;
    pat_tab[4] = 7'h19; pat_tab[5] = 7'h12; pat_tab[6] = 7'h02; pat_tab[7] = 7'h78;
    pat_tab[8] = 7'h00; pat_tab[9] = 7'h10;

    tab[0] = '{sel: 0, val: 13,   z: 0, cout: 1, poke: 0, exp: {LZB, LZB, 7'h79, 7'h30}};
    tab[1] = '{sel: 0, val: 0,    z: 1, cout: 0, poke: 0, exp: {LZB, LZB, LZB, 7'h40}};
    tab[2] = '{sel: 0, val: 13,   z: 0, cout: 1, poke: 1, exp: {LZB, LZB, 7'h79, 7'h30}};
    tab[3] = '{sel: 1, val: 8191, z: 0, cout: 1, poke: 0, exp: {7'h00, 7'h79, 7'h10, 7'h79}};
    tab[4] = '{sel: 1, val: 1000, z: 0, cout: 0, poke: 0, exp: {7'h79, 7'h40, 7'h40, 7'h40}};
    tab[5] = '{sel: 1, val: 205,  z: 1, cout: 1, poke: 0, exp: {LZB, 7'h24, 7'h40, 7'h12}};
    tab[6] = '{sel: 2, val: 1,    z: 0, cout: 0, poke: 0, exp: {LZB, LZB, LZB, 7'h79}};
    tab[7] = '{sel: 2, val: 0,    z: 1, cout: 0, poke: 0, exp: {LZB, LZB, LZB, 7'h40}};

    // Clock/reset
    rst_n = 1'b0;
    valid = '0;
    res   = '0;
    z     = 1'b0;
    cout  = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset seg%0d", s), 32'(seg_a[s]), 32'h7F);
      chk($sformatf("reset an%0d", s), 32'(an_a[s]), 32'hF);
      chk($sformatf("reset ready%0d", s), 32'(rdy[s]), 32'd1);
      chk($sformatf("reset leds%0d", s), {30'd0, lz[s], lc[s]}, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("release an", 32'(an_a[0]), 32'hE);
    chk("release seg", 32'(seg_a[0]), 32'h40);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      send(tab[i].sel, tab[i].val, tab[i].z, tab[i].cout, tab[i].poke, tab[i].exp,
           $sformatf("vec%0d", i));
    end

    // Randomized against the reference model
    for (int i = 0; i < 12; i++) begin
      int s = (i < 6) ? 1 : ((i < 10) ? 0 : 2);
      v  = int'($urandom_range(0, (1 << wid(s)) - 1));
      rz = 1'($urandom);
      rc = 1'($urandom);
      send(s, v, rz, rc, 1'b0, model_digits(v), $sformatf("rnd%0d_v%0d", i, v));
    end

    // Back-to-back: capture again on the first edge in_ready is high.
    wait_ready(0, "b2b");
    res = 13'd5; valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    wait_ready(0, "b2b first");
    res = 13'd7; z = 1'b1; cout = 1'b1; valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    chk("b2b accepted", 32'(rdy[0]), 32'd0);
    wait_ready(0, "b2b second");
    chk("b2b leds", {30'd0, lz[0], lc[0]}, 32'd3);
    push_exp(model_digits(7));
    read_digits(0, "b2b");

    // Reset in the middle of a conversion
    wait_ready(0, "midrst");
    res = 13'd9; z = 1'b1; cout = 1'b1; valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst ready", 32'(rdy[0]), 32'd1);
    chk("midrst an", 32'(an_a[0]), 32'hF);
    chk("midrst seg", 32'(seg_a[0]), 32'h7F);
    rst_n = 1'b1;
    tick();
    chk("midrst release an", 32'(an_a[0]), 32'hE);
    chk("midrst release seg", 32'(seg_a[0]), 32'h40);
    chk("midrst leds", {30'd0, lz[0], lc[0]}, 32'd0);

    // Scan order and dwell time
    scan_seq[0] = 4'hD; scan_seq[1] = 4'hB; scan_seq[2] = 4'h7; scan_seq[3] = 4'hE;
    run = 0;
    while (an_a[0] == 4'hE && run < 10) begin
      tick();
      run++;
    end
    for (int k = 0; k < 4; k++) begin
      run = 0;
      while (an_a[0] == scan_seq[k] && run < 10) begin
        tick();
        run++;
      end
      chk($sformatf("scan dwell an=%0h", scan_seq[k]), 32'(run), 32'(RD));
    end
    chk("scan wrap", 32'(an_a[0]), 32'hD);
    push_exp(model_digits(0));
    read_digits(0, "midrst display");
    chk("midrst ready after", 32'(rdy[0]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_result_display.md
# alu_result_display

Downstream output stage for the parametrizable ALU: captures `ALUResult`, `Z` and `Cout` on a valid/ready handshake, converts the unsigned result to decimal BCD with a sequential shift-add-3 engine, and drives a 4-digit multiplexed active-low 7-segment display plus two flag LEDs. It sits between the ALU and the board display pins, replacing raw LED display of the result.

## Interface
- `WIDTH`, 4: ALU result width; legal range 1..13, so the maximum value 8191 fits in 4 decimal digits.
- `REFRESH_DIV`, 100000: clock cycles each digit stays lit; legal values are 2 and above.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  source presents a result to capture.
- `in_ready`  out  1  block can accept a capture.
- `alu_result`  in  WIDTH  unsigned ALU result.
- `alu_z`  in  1  ALU zero flag.
- `alu_cout`  in  1  ALU carry-out flag.
- `seg`  out  7  segment outputs {g,f,e,d,c,b,a}, active-low.
- `an`  out  4  digit anodes, active-low, one-hot; `an[0]` is the units digit.
- `led_z`  out  1  captured zero flag.
- `led_cout`  out  1  captured carry flag.

## Operation
- Capture happens on an edge where `in_valid && in_ready`. It latches `alu_result`, `alu_z` and `alu_cout`, and the FSM moves IDLE → CONVERT.
- CONVERT runs WIDTH cycles. Each cycle, every BCD nibble ≥5 gets +3, then {bcd,bin} shifts left by 1. After the WIDTH-th shift the FSM goes to DONE.
- DONE lasts 1 cycle. It copies the 16-bit BCD into the display register and the latched flags into `led_z`/`led_cout` in the same edge, so digits and flags update together. The FSM then returns to IDLE.
- `in_ready` = 1 only in IDLE. `in_valid` outside IDLE is ignored; the source holds `in_valid` until it sees ready.
- Scan counter counts 0..REFRESH_DIV-1. On wrap, digit index goes 0→1→2→3→0.
- `an` = ~(1 << index). `seg` is the decode of the selected BCD nibble.
- Segment patterns: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, blank=7Fh.
- Scanning runs continuously, independent of the conversion FSM. The display keeps showing the previous result until DONE.

## Timing
- Reset values: `seg`=7Fh, `an`=Fh, `in_ready`=1, `led_z`=0, `led_cout`=0. Display register, scan counter, digit index and FSM (IDLE) all clear.
- First cycle after reset release: `an`=Eh and `seg`=40h (digit "0").
- Latency: capture at edge N, display and LEDs updated at edge N+WIDTH+1. `in_ready` is low for WIDTH+1 cycles and high again from edge N+WIDTH+1.
- Back-to-back: a new capture is accepted on the first edge `in_ready` is high.
- Reset during CONVERT or DONE: the conversion is discarded and all state returns to reset values on that edge.
- A change in `alu_result` after capture has no effect on the conversion in progress.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: digits 3..1 show blank (7Fh) when they and all higher digits are 0; digit 0 is never blanked.
- `LEADING_ZERO_BLANK_EN` not defined: all four digits always show their value, including leading zeros ("0013").

## Structure
- Package `alu_display_pkg` holds:
  - the FSM state enum (IDLE, CONVERT, DONE);
  - the 7-segment pattern constants for 0–9 and blank;
  - the digit-count constant (4).
- Sub-module `alu_bin2bcd` holds the sequential double-dabble engine and its counter, with start/done handshake to the top.
- Scan counter, anode decode, segment decode and the flag registers stay in the top module.

## Test plan
- Reset, REFRESH_DIV=4: hold `rst_n`=0 for 2 cycles → `seg`=7Fh, `an`=Fh, `in_ready`=1, LEDs 0. After release → `an`=Eh, `seg`=40h.
- Capture, WIDTH=4, `alu_result`=1101b, z=0, cout=1:
  - `in_ready` low for exactly 5 cycles;
  - digits 1,0 show 79h,30h ("13"); `led_cout`=1, `led_z`=0;
  - digits 3,2 are 7Fh with the macro, 40h without.
- Result 0000b with z=1 → all digits "0" (digit 0 only with the macro), `led_z`=1, `led_cout`=0.
- In-flight ignore: `in_valid` with 0010b during CONVERT → ignored; the display still shows 13 afterwards.
- Width extremes:
  - WIDTH=13, result 8191 → digits 3..0 show 00h,79h,10h,79h after 14 cycles;
  - WIDTH=1, result 1 → "1" after 2 cycles.
- Reset mid-CONVERT, then scan check with REFRESH_DIV=4:
  - reset → next edge `in_ready`=1, display 0, LEDs 0;
  - `an` cycles E,D,B,7 at 4 cycles each and wraps back to E.
